// File: rtl/flash_reader_if.sv
// flash_reader_if -- bundle of the read-request handshake, the word output
// stream and the single-bit SPI pins of flash_reader.
//   slave  : the reader itself (takes requests, drives SPI and data_o)
//   master : the requester / consumer side, which also sits on the flash pins
//   start, addr[23:0], num_words[15:0]  request (start is a 1-cycle pulse)
//   busy, done                          transaction status
//   data_o[31:0], data_valid, data_ready  word stream with valid/ready
//   flash_c, flash_sb, flash_d, flash_q   SPI clock, select (low), MOSI, MISO
interface flash_reader_if;
    logic        start;
    logic [23:0] addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic [31:0] data_o;
    logic        data_valid;
    logic        data_ready;
    logic        flash_c;
    logic        flash_sb;
    logic        flash_d;
    logic        flash_q;

    modport slave (
        input  start, addr, num_words, data_ready, flash_q,
        output busy, done, data_o, data_valid, flash_c, flash_sb, flash_d
    );

    modport master (
        output start, addr, num_words, data_ready, flash_q,
        input  busy, done, data_o, data_valid, flash_c, flash_sb, flash_d
    );
endinterface

// File: rtl/flash_reader.sv
// flash_reader -- reads num_words 32-bit big-endian words from a SPI flash
// starting at byte address addr, using the plain READ command (0x03) in
// single-bit mode 0, and streams them out over a valid/ready port.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; aborts any transaction in flight
//   bus    flash_reader_if.slave (request, status, word stream, SPI pins)
// Parameters:
//   CLK_DIV       clk cycles per flash_c half-period (1..255)
//   DESEL_CYCLES  minimum clk cycles flash_sb stays high after a transaction
module flash_reader #(
    parameter int CLK_DIV      = 2,
    parameter int DESEL_CYCLES = 4
) (
    input logic           clk,
    input logic           reset,
    flash_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STALL, DESEL} state_t;

    state_t      state;
    logic [15:0] cnt;         // half-period timer while clocking, deselect timer in DESEL
    logic [4:0]  bit_cnt;     // bits sampled, modulo 32 (cmd+addr is exactly one 32-bit frame)
    logic [31:0] sr;          // outgoing cmd/addr in CMD/ADDR, incoming word in DATA
    logic [15:0] words_left;

    logic phase_end;
    logic can_accept;
    logic last_word;
    logic word_done;
    logic word_xfer;

    assign phase_end  = (cnt == 16'(CLK_DIV - 1));
    assign can_accept = !bus.data_valid || bus.data_ready;
    assign last_word  = (words_left == 16'd1);
    // A word is complete at the falling edge that follows its 32nd sample;
    // handing it over there means flash_c is already low if we must stall.
    assign word_done  = (state == DATA) && phase_end && bus.flash_c && (bit_cnt == 5'd0);
    assign word_xfer  = can_accept && (word_done || state == STALL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            sr             <= '0;
            words_left     <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.data_o     <= '0;
            bus.data_valid <= 1'b0;
            bus.flash_c    <= 1'b0;
            bus.flash_sb   <= 1'b1;
            bus.flash_d    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.data_valid && bus.data_ready)
                bus.data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start && !bus.data_valid) begin
                        if (bus.num_words == 16'd0) begin
                            bus.done <= 1'b1;
                        end else begin
                            state        <= CMD;
                            bus.busy     <= 1'b1;
                            bus.flash_sb <= 1'b0;
                            sr           <= {8'h03, bus.addr};
                            bus.flash_d  <= 1'b0;   // MSB of 0x03
                            words_left   <= bus.num_words;
                            cnt          <= '0;
                            bit_cnt      <= '0;
                        end
                    end
                end

                CMD, ADDR, DATA: begin
                    if (!phase_end) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        cnt         <= '0;
                        bus.flash_c <= !bus.flash_c;
                        if (!bus.flash_c) begin
                            // rising edge: the flash latches flash_d, we take flash_q
                            bit_cnt <= bit_cnt + 5'd1;
                            if (state == DATA)
                                sr <= {sr[30:0], bus.flash_q};
                        end else if (state != DATA) begin
                            // falling edge: present the next outgoing bit
                            sr          <= {sr[30:0], 1'b0};
                            bus.flash_d <= sr[30];
                            if (state == CMD && bit_cnt == 5'd8)
                                state <= ADDR;
                            if (state == ADDR && bit_cnt == 5'd0) begin
                                state       <= DATA;
                                bus.flash_d <= 1'b0;
                            end
                        end else if (word_done && !can_accept) begin
                            state <= STALL;
                        end
                    end
                end

                STALL: begin
                    // restart the low phase from zero so it is never short
                    if (can_accept) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end

                DESEL: begin
                    if (cnt == 16'(DESEL_CYCLES - 1)) begin
                        state    <= IDLE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase

            if (word_xfer) begin
                bus.data_o     <= sr;
                bus.data_valid <= 1'b1;
                words_left     <= words_left - 16'd1;
                if (last_word) begin
                    state        <= DESEL;
                    bus.flash_sb <= 1'b1;
                    cnt          <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_flash_reader.sv
// tb_flash_reader -- directed bench for flash_reader. A behavioural SPI flash
// captures the command/address bits and streams back the words in fw[];
// a single per-cycle compare process checks SPI timing rules, flash_d idle
// level, output hold under backpressure and the word stream against a queue;
// the main sequence adds hand-computed literal expectations per scenario.
module tb_flash_reader;
    localparam int CLK_DIV = 2;
    localparam int DESEL   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    flash_reader_if bus();

    logic        start;
    logic [23:0] addr;
    logic [15:0] num_words;
    logic        data_ready;
    logic        q_drv = 1'b0;

    assign bus.start      = start;
    assign bus.addr       = addr;
    assign bus.num_words  = num_words;
    assign bus.data_ready = data_ready;
    assign bus.flash_q    = q_drv;

    flash_reader #(.CLK_DIV(CLK_DIV), .DESEL_CYCLES(DESEL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural flash ----------------
    int          rx_bits = 0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] fw [8];
    int          fb, fwi;

    always @(negedge bus.flash_sb) begin
        rx_bits  = 0;
        cmd_addr = '0;
    end

    always @(posedge bus.flash_c) if (!bus.flash_sb) begin
        if (rx_bits < 32) cmd_addr = {cmd_addr[30:0], bus.flash_d};
        rx_bits++;
    end

    always @(negedge bus.flash_c) if (!bus.flash_sb && rx_bits >= 32) begin
        fb  = rx_bits - 32;
        fwi = fb / 32;
        q_drv = (fwi < 8) ? fw[fwi][31 - (fb % 32)] : 1'b0;
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] exp_q [$];
    logic [31:0] last_data = '0;
    logic [31:0] prev_data = '0;
    logic        prev_c = 1'b0, prev_sb = 1'b1, prev_valid = 1'b0, prev_ready = 1'b0;
    logic        rise_pend = 1'b0, sb_low_seen = 1'b0, busy_seen = 1'b0;
    int cyc = 0, run = 0, max_low_run = 0, sb_hi_run = 0, last_gap = 0;
    int pops = 0, done_cnt = 0;
    int t_start = 0, t_sb = 0, t_rise = 0, t_done = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (bus.start) t_start = cyc;
            if (!bus.flash_sb) sb_low_seen = 1'b1;
            if (bus.busy) busy_seen = 1'b1;
            if (bus.flash_sb)
                chk("c_low_when_desel", bus.flash_c == 1'b0, bus.flash_c, 0);
            if (bus.flash_sb || rx_bits > 32 || (rx_bits == 32 && !bus.flash_c))
                chk("d_idle_zero", bus.flash_d == 1'b0, bus.flash_d, 0);
            if (!bus.flash_sb) begin
                if (bus.flash_c == prev_c) run++;
                else begin
                    chk("half_period", run >= CLK_DIV, run, CLK_DIV);
                    run = 1;
                end
                if (!bus.flash_c && run > max_low_run) max_low_run = run;
            end else run = 0;
            if (prev_sb && !bus.flash_sb) begin
                t_sb = cyc; rise_pend = 1'b1; last_gap = sb_hi_run;
            end
            if (!prev_c && bus.flash_c && rise_pend) begin
                t_rise = cyc; rise_pend = 1'b0;
            end
            if (prev_valid && !prev_ready)
                chk("hold", bus.data_valid && bus.data_o == prev_data, bus.data_o, prev_data);
            if (bus.data_valid && bus.data_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", 1'b0, bus.data_o, 0);
                else begin
                    chk("word_order", bus.data_o == exp_q[0], bus.data_o, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                last_data = bus.data_o;
                pops++;
            end
            if (bus.done) begin
                done_cnt++; t_done = cyc;
                chk("busy_low_at_done", bus.busy == 1'b0, bus.busy, 0);
            end
        end
        sb_hi_run  = bus.flash_sb ? sb_hi_run + 1 : 0;
        prev_c     = bus.flash_c;
        prev_sb    = bus.flash_sb;
        prev_valid = bus.data_valid;
        prev_ready = bus.data_ready;
        prev_data  = bus.data_o;
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [23:0] a, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; addr = a; num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int k;
        k = 0;
        while (!bus.done && k < bound) begin @(negedge clk); k++; end
        chk(name, bus.done == 1'b1, k, bound);
    endtask

    task automatic wait_bits(input int target, input int bound, input string name);
        int k;
        k = 0;
        while (rx_bits < target && k < bound) begin @(negedge clk); k++; end
        chk(name, rx_bits >= target, rx_bits, target);
    endtask

    int d0, p0;

    initial begin
        reset = 1'b1; start = 1'b0; addr = '0; num_words = '0; data_ready = 1'b1;
        for (int i = 0; i < 8; i++) fw[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_sb",    bus.flash_sb == 1'b1,   bus.flash_sb, 1);
        chk("rst_c",     bus.flash_c == 1'b0,    bus.flash_c, 0);
        chk("rst_d",     bus.flash_d == 1'b0,    bus.flash_d, 0);
        chk("rst_busy",  bus.busy == 1'b0,       bus.busy, 0);
        chk("rst_done",  bus.done == 1'b0,       bus.done, 0);
        chk("rst_valid", bus.data_valid == 1'b0, bus.data_valid, 0);
        chk("rst_data",  bus.data_o == 32'h0,    bus.data_o, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single word read
        fw[0] = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
        d0 = done_cnt; p0 = pops;
        do_start(24'h123456, 16'd1);
        wait_done(2000, "t1_timeout");
        repeat (10) @(negedge clk);
        chk("t1_mosi",       cmd_addr == 32'h03123456, cmd_addr, 32'h03123456);
        chk("t1_pulses",     rx_bits == 64, rx_bits, 64);
        chk("t1_sb_fall",    t_sb - t_start == 1, t_sb - t_start, 1);
        chk("t1_first_rise", t_rise - t_sb == CLK_DIV, t_rise - t_sb, CLK_DIV);
        chk("t1_done_once",  done_cnt - d0 == 1, done_cnt - d0, 1);
        chk("t1_words",      pops - p0 == 1, pops - p0, 1);
        chk("t1_data",       last_data == 32'hDEADBEEF, last_data, 32'hDEADBEEF);

        // backpressure: four words, consumer stalled
        fw[0] = 32'h01234567; fw[1] = 32'h89ABCDEF; fw[2] = 32'hCAFEF00D; fw[3] = 32'h5A5AA5A5;
        for (int i = 0; i < 4; i++) exp_q.push_back(fw[i]);
        d0 = done_cnt; p0 = pops; max_low_run = 0;
        data_ready = 1'b0;
        do_start(24'h000100, 16'd4);
        wait_bits(96, 3000, "t2_reach_word3");
        repeat (120) @(negedge clk);
        chk("t2_no_progress", rx_bits == 96, rx_bits, 96);
        chk("t2_c_low",       bus.flash_c == 1'b0, bus.flash_c, 0);
        chk("t2_sb_low",      bus.flash_sb == 1'b0, bus.flash_sb, 0);
        chk("t2_stall_len",   max_low_run >= 100, max_low_run, 100);
        chk("t2_held_word",   bus.data_valid && bus.data_o == 32'h01234567, bus.data_o, 32'h01234567);
        @(posedge clk); #1; data_ready = 1'b1;
        wait_done(3000, "t2_timeout");
        repeat (10) @(negedge clk);
        chk("t2_words",  pops - p0 == 4, pops - p0, 4);
        chk("t2_last",   last_data == 32'h5A5AA5A5, last_data, 32'h5A5AA5A5);
        chk("t2_pulses", rx_bits == 160, rx_bits, 160);
        chk("t2_done",   done_cnt - d0 == 1, done_cnt - d0, 1);

        // zero-length request
        d0 = done_cnt; sb_low_seen = 1'b0; busy_seen = 1'b0;
        do_start(24'hABCDEF, 16'd0);
        wait_done(10, "t3_timeout");
        repeat (5) @(negedge clk);
        chk("t3_done_lat", t_done - t_start == 1, t_done - t_start, 1);
        chk("t3_done",     done_cnt - d0 == 1, done_cnt - d0, 1);
        chk("t3_sb_high",  sb_low_seen == 1'b0, sb_low_seen, 0);
        chk("t3_no_busy",  busy_seen == 1'b0, busy_seen, 0);
        chk("t3_no_valid", bus.data_valid == 1'b0, bus.data_valid, 0);

        // start while busy is ignored
        fw[0] = 32'h13579BDF; fw[1] = 32'h2468ACE0;
        exp_q.push_back(32'h13579BDF); exp_q.push_back(32'h2468ACE0);
        d0 = done_cnt; p0 = pops;
        do_start(24'h00ABCD, 16'd2);
        wait_bits(40, 2000, "t4_reach_data");
        do_start(24'hFFFFFF, 16'd5);
        wait_done(2000, "t4_timeout");
        repeat (10) @(negedge clk);
        chk("t4_mosi",   cmd_addr == 32'h0300ABCD, cmd_addr, 32'h0300ABCD);
        chk("t4_pulses", rx_bits == 96, rx_bits, 96);
        chk("t4_words",  pops - p0 == 2, pops - p0, 2);
        chk("t4_done",   done_cnt - d0 == 1, done_cnt - d0, 1);

        // reset during the address phase
        do_start(24'h654321, 16'd2);
        wait_bits(12, 1000, "t5_reach_addr");
        @(posedge clk); #1; reset = 1'b1; #1;
        chk("t5_sb_now", bus.flash_sb == 1'b1, bus.flash_sb, 1);
        chk("t5_c_now",  bus.flash_c == 1'b0, bus.flash_c, 0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_no_done",  done_cnt == d0, done_cnt, d0);
        chk("t5_no_valid", bus.data_valid == 1'b0, bus.data_valid, 0);
        fw[0] = 32'h0BADF00D; fw[1] = 32'hFEEDFACE;
        exp_q.push_back(32'h0BADF00D); exp_q.push_back(32'hFEEDFACE);
        p0 = pops;
        do_start(24'h000004, 16'd2);
        wait_done(2000, "t5_timeout");
        repeat (10) @(negedge clk);
        chk("t5_mosi",  cmd_addr == 32'h03000004, cmd_addr, 32'h03000004);
        chk("t5_words", pops - p0 == 2, pops - p0, 2);
        chk("t5_last",  last_data == 32'hFEEDFACE, last_data, 32'hFEEDFACE);

        // back-to-back transactions
        fw[0] = 32'h11223344; exp_q.push_back(32'h11223344);
        do_start(24'h100000, 16'd1);
        wait_done(2000, "t6a_timeout");
        fw[0] = 32'h55667788; exp_q.push_back(32'h55667788);
        do_start(24'h200000, 16'd1);
        wait_done(2000, "t6b_timeout");
        repeat (10) @(negedge clk);
        chk("t6_gap",   last_gap >= DESEL, last_gap, DESEL);
        chk("t6_mosi",  cmd_addr == 32'h03200000, cmd_addr, 32'h03200000);
        chk("t6_last",  last_data == 32'h55667788, last_data, 32'h55667788);
        chk("t6_drain", exp_q.size() == 0, exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
